// File: rtl/bscan_pkg.sv
// Shared definitions for the boundary-scan TAP controller: TAP state codes,
// instruction opcodes and the pattern captured into the IR.
package bscan_pkg;

  // Codes follow the common 1149.1 state numbering so waveforms read familiar.
  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  localparam logic [3:0] EXTEST = 4'b0000;
  localparam logic [3:0] SAMPLE = 4'b0001;
  localparam logic [3:0] BYPASS = 4'b1111;

  // Low bits of the IR capture value; upper bits are zero-filled.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic logic is_shift_state(input tap_state_e s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/bscan_tap_ctrl_if.sv
// Port bundle between a JTAG driver and the TAP controller.
interface bscan_tap_ctrl_if #(
  parameter int IR_W = 4
);
  import bscan_pkg::*;

  // tms/tdi are sampled on every rising clk edge; there is no valid/ready,
  // every cycle is one transfer and every output reflects the state reached
  // after the most recent edge.
  logic             tms;
  logic             tdi;
  tap_state_e       state;
  logic             capture_dr;
  logic             shift_dr;
  logic             update_dr;
  logic             capture_ir;
  logic             shift_ir;
  logic             update_ir;
  logic             tap_reset;
  logic [IR_W-1:0]  instr;
  logic             mode;
  logic             bypass_sel;
  logic             ir_tdo;
  logic             tdo_en;

  modport master (
    output tms, tdi,
    input  state, capture_dr, shift_dr, update_dr,
    input  capture_ir, shift_ir, update_ir,
    input  tap_reset, instr, mode, bypass_sel, ir_tdo, tdo_en
  );

  modport slave (
    input  tms, tdi,
    output state, capture_dr, shift_dr, update_dr,
    output capture_ir, shift_ir, update_ir,
    output tap_reset, instr, mode, bypass_sel, ir_tdo, tdo_en
  );

endinterface

// File: rtl/bscan_ir.sv
// Instruction register: serial shift stage plus the parallel update latch
// that holds the active instruction.
module bscan_ir
  import bscan_pkg::*;
#(
  parameter int              IR_W        = 4,
  parameter logic [IR_W-1:0] RESET_INSTR = IR_W'(BYPASS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tlr_load,
  input  logic            capture,
  input  logic            shift,
  input  logic            update,
  input  logic            tdi,
  output logic [IR_W-1:0] instr,
  output logic            tdo
);

  logic [IR_W-1:0] sr;

  // tlr_load is asserted while Test-Logic-Reset is being entered or held, so
  // both registers already carry RESET_INSTR in the first TLR cycle.
  always_ff @(posedge clk) begin
    if (rst || tlr_load) begin
      sr    <= RESET_INSTR;
      instr <= RESET_INSTR;
    end else begin
      if (capture) begin
        sr <= IR_W'(IR_CAPTURE);
      end else if (shift) begin
        sr <= {tdi, sr[IR_W-1:1]};
      end
      if (update) begin
        instr <= sr;
      end
    end
  end

  assign tdo = sr[0];

endmodule

// File: rtl/bscan_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, Moore-decoded DR/IR strobes and
// instruction decode. Boundary-scan cells live outside this block.
module bscan_tap_ctrl
  import bscan_pkg::*;
#(
  parameter int              IR_W        = 4,
  parameter logic [IR_W-1:0] RESET_INSTR = IR_W'(BYPASS)
) (
  input  logic                clk,
  input  logic                rst,
  bscan_tap_ctrl_if.slave     bus
);

  tap_state_e      state;
  tap_state_e      next_state;
  logic [IR_W-1:0] instr;
  logic            ir_tdo;

  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic capture_ir;
  logic shift_ir;
  logic update_ir;
  logic tap_reset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TLR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = bus.tms ? TLR      : RTI;
      RTI:      next_state = bus.tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = bus.tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = bus.tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = bus.tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = bus.tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = bus.tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = bus.tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = bus.tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = bus.tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = bus.tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = bus.tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = bus.tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = bus.tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = bus.tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = bus.tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // Strobes are pure state decodes, so each is high for exactly the cycles
  // spent in its state.
  always_comb begin
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    tap_reset  = 1'b0;
    case (state)
      CAP_DR:   capture_dr = 1'b1;
      SHIFT_DR: shift_dr   = 1'b1;
      UPD_DR:   update_dr  = 1'b1;
      CAP_IR:   capture_ir = 1'b1;
      SHIFT_IR: shift_ir   = 1'b1;
      UPD_IR:   update_ir  = 1'b1;
      TLR:      tap_reset  = 1'b1;
      default:  ;
    endcase
  end

  bscan_ir #(
    .IR_W        (IR_W),
    .RESET_INSTR (RESET_INSTR)
  ) u_ir (
    .clk      (clk),
    .rst      (rst),
    .tlr_load (next_state == TLR),
    .capture  (capture_ir),
    .shift    (shift_ir),
    .update   (update_ir),
    .tdi      (bus.tdi),
    .instr    (instr),
    .tdo      (ir_tdo)
  );

  assign bus.state      = state;
  assign bus.capture_dr = capture_dr;
  assign bus.shift_dr   = shift_dr;
  assign bus.update_dr  = update_dr;
  assign bus.capture_ir = capture_ir;
  assign bus.shift_ir   = shift_ir;
  assign bus.update_ir  = update_ir;
  assign bus.tap_reset  = tap_reset;
  assign bus.instr      = instr;
  assign bus.ir_tdo     = ir_tdo;
  assign bus.tdo_en     = is_shift_state(state);

  // Any opcode other than EXTEST/SAMPLE routes TDI through the bypass bit.
  assign bus.mode       = (instr == IR_W'(EXTEST));
  assign bus.bypass_sel = (instr != IR_W'(EXTEST)) && (instr != IR_W'(SAMPLE));

endmodule

// File: doc/bscan_tap_ctrl.md
BSCAN_TAP_CTRL -- requirements
Module: bscan_tap_ctrl

Interface
REQ-001 Parameter IR_W, default 4: instruction register width in bits.
REQ-002 Parameter RESET_INSTR, default 4'b1111: instruction loaded on reset and in Test-Logic-Reset (BYPASS).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tms  input  1  test mode select; sampled each rising edge of clk.
REQ-006 tdi  input  1  serial test data in; feeds the IR shift register.
REQ-007 state  output  4  current TAP state code, from the shared package.
REQ-008 capture_dr, shift_dr, update_dr  output  1 each  data-register control strobes driving the boundary-scan cell flops.
REQ-009 capture_ir, shift_ir, update_ir  output  1 each  instruction-register control strobes.
REQ-010 tap_reset  output  1  high while in Test-Logic-Reset.
REQ-011 instr  output  IR_W  currently active (updated) instruction.
REQ-012 mode  output  1  high when instr == EXTEST (4'b0000); selects cell output over functional path.
REQ-013 bypass_sel  output  1  high when instr is neither EXTEST nor SAMPLE (4'b0001).
REQ-014 ir_tdo  output  1  IR shift register bit 0, serial IR output.
REQ-015 tdo_en  output  1  high in Shift-DR or Shift-IR only.

Function
REQ-016 The FSM SHALL implement the 16 IEEE 1149.1 TAP states with standard TMS transitions (e.g. Run-Test-Idle -tms1-> Select-DR -tms1-> Select-IR -tms1-> Test-Logic-Reset).
REQ-017 Five consecutive tms=1 edges SHALL reach Test-Logic-Reset from any state.
REQ-018 All strobe outputs SHALL be Moore decodes of state; each is high exactly in its matching state (capture_dr in Capture-DR, etc.), so update_dr/update_ir last one cycle per visit.
REQ-019 In Capture-IR, the IR shift register SHALL load {IR_W-2 zeros, 2'b01}.
REQ-020 In Shift-IR, the shift register SHALL take {tdi, sr[IR_W-1:1]} each clk; ir_tdo shows sr[0] prior to the shift.
REQ-021 In Update-IR, instr SHALL load the shift register value; instr is held in all other states.
REQ-022 In Test-Logic-Reset, instr SHALL equal RESET_INSTR and the shift register SHALL hold RESET_INSTR.
REQ-023 Exit1/Exit2/Pause states SHALL hold the shift register unchanged.
REQ-024 mode and bypass_sel SHALL decode instr combinationally; they change only the cycle after Update-IR or Test-Logic-Reset entry.
REQ-025 Pause-IR with tms=0 SHALL hold indefinitely without altering instr or shift contents.

Reset
REQ-026 rst high on a clk edge SHALL force state = Test-Logic-Reset, instr = RESET_INSTR, shift register = RESET_INSTR, regardless of tms or current state (including mid Shift-IR).
REQ-027 After reset: tap_reset=1, all capture/shift/update strobes=0, tdo_en=0, mode=0, bypass_sel=1, ir_tdo=1.

Structure
REQ-028 Shared package bscan_pkg SHALL hold the 4-bit TAP state encodings, instruction opcodes EXTEST, SAMPLE, BYPASS, and the IR capture pattern.
REQ-029 The IR (shift register, update latch) SHALL be one sub-module, bscan_ir, instantiated once; the FSM and decode stay in bscan_tap_ctrl.
REQ-030 The block SHALL only sequence DR cells via strobes; it SHALL NOT contain boundary-scan cell storage.

Verification
REQ-031 rst=1 one cycle from Shift-DR -> next cycle state=TLR, instr=4'b1111, bypass_sel=1, mode=0.
REQ-032 From Run-Test-Idle, tms=1,1,1,1,1 -> TLR after fifth edge; from each of the 16 states likewise.
REQ-033 Load EXTEST: TLR, tms 0,1,1,0,0 (Shift-IR), tdi=0,0,0,0 with tms=0,0,0,1, then tms 1 -> Update-IR; ir_tdo sequence 1,0,0,0; instr=4'b0000, mode=1 the cycle after Update-IR.
REQ-034 DR walk: Run-Test-Idle, tms 1,0,0,0,0,1,1 -> capture_dr one cycle, shift_dr three cycles, update_dr one cycle, tdo_en equal to shift_dr; instr unchanged.
REQ-035 Pause hold: in Shift-IR after two bits, tms 1,0 to Pause-IR for 10 cycles, then tms 1,0 resumes Shift-IR -> shift contents identical before and after pause.
